// File: rtl/mmio_ctrl_regs.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mmio_ctrl_regs: per-channel MMIO control/status register bank and job FSM.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mmio_ctrl_regs #(
  parameter int          NUM_CH     = 2,
  parameter int          ADDR_WIDTH = 64,
  parameter int          SIZE_WIDTH = 32,
  parameter logic [15:0] BASE_ADDR  = 16'h0050,
  parameter logic [15:0] CH_STRIDE  = 16'h0010
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mmio_wr_en,
  input  logic [15:0]                    mmio_wr_addr,
  input  logic [63:0]                    mmio_wr_data,
  input  logic                           mmio_rd_en,
  input  logic [15:0]                    mmio_rd_addr,
  output logic [63:0]                    mmio_rd_data,
  output logic [NUM_CH*ADDR_WIDTH-1:0]   start_addr,
  output logic [NUM_CH*SIZE_WIDTH-1:0]   size,
  output logic [NUM_CH-1:0]              go,
  output logic [NUM_CH-1:0]              soft_reset,
  output logic [NUM_CH-1:0]              unhalt,
  input  logic [NUM_CH-1:0]              done
);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic                    w_wr_even;
  logic                    w_rd_even;
  logic [NUM_CH-1:0][63:0] w_rd_ch;
  logic [63:0]             w_rd_mux;
  logic [63:0]             r_rd_data;
  logic                    w_unused_wr_data;

  assign w_wr_even = mmio_wr_en & ~mmio_wr_addr[0];
  assign w_rd_even = ~mmio_rd_addr[0];

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      localparam logic [15:0] c_CH_BASE = 16'(BASE_ADDR + 16'(c) * CH_STRIDE);

      logic [1:0]            r_state;
      logic [1:0]            w_state_nxt;
      logic                  r_go;
      logic                  r_soft_reset;
      logic                  r_unhalt;
      logic [ADDR_WIDTH-1:0] r_start;
      logic [SIZE_WIDTH-1:0] r_size;
      logic [31:0]           r_cycles;
      logic                  r_done_sticky;
      logic                  r_err_sticky;

      logic w_wr_ctrl, w_wr_start, w_wr_size, w_wr_status;
      logic w_srst, w_go_req, w_size_zero, w_busy;
      logic w_launch, w_zero_job, w_busy_go, w_finish, w_count;
      logic [63:0] w_rd_val;

      assign w_wr_ctrl   = w_wr_even && (mmio_wr_addr == c_CH_BASE);
      assign w_wr_start  = w_wr_even && (mmio_wr_addr == c_CH_BASE + 16'd2);
      assign w_wr_size   = w_wr_even && (mmio_wr_addr == c_CH_BASE + 16'd4);
      assign w_wr_status = w_wr_even && (mmio_wr_addr == c_CH_BASE + 16'd6);

      // A CTRL write updates soft_reset in the same cycle it may request go,
      // so the value being written decides whether the go is honoured.
      assign w_srst      = w_wr_ctrl ? mmio_wr_data[1] : r_soft_reset;
      assign w_go_req    = w_wr_ctrl & mmio_wr_data[0];
      assign w_size_zero = (r_size == '0);
      assign w_busy      = (r_state == c_BUSY);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= c_IDLE;
        end else begin
          r_state <= w_state_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        if (w_srst) begin
          w_state_nxt = c_IDLE;
        end else begin
          case (r_state)
            c_IDLE, c_DONE: begin
              if (w_go_req) begin
                w_state_nxt = w_size_zero ? c_DONE : c_BUSY;
              end
            end
            c_BUSY: begin
              if (done[c]) begin
                w_state_nxt = c_DONE;
              end
            end
            default: w_state_nxt = c_IDLE;
          endcase
        end
      end

      always_comb begin
        w_launch   = 1'b0;
        w_zero_job = 1'b0;
        w_busy_go  = 1'b0;
        w_finish   = 1'b0;
        w_count    = 1'b0;
        if (!w_srst) begin
          if (w_busy) begin
            w_count   = 1'b1;
            w_busy_go = w_go_req;
            w_finish  = done[c];
          end else begin
            w_launch   = w_go_req & ~w_size_zero;
            w_zero_job = w_go_req & w_size_zero;
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_go          <= 1'b0;
          r_soft_reset  <= 1'b0;
          r_unhalt      <= 1'b0;
          r_start       <= '0;
          r_size        <= '0;
          r_cycles      <= '0;
          r_done_sticky <= 1'b0;
          r_err_sticky  <= 1'b0;
        end else begin
          r_go <= w_launch;
          if (w_wr_ctrl) begin
            r_soft_reset <= mmio_wr_data[1];
            r_unhalt     <= mmio_wr_data[2];
          end
          if (w_wr_start && !w_busy) begin
            r_start <= mmio_wr_data[ADDR_WIDTH-1:0];
          end
          if (w_wr_size && !w_busy) begin
            r_size <= mmio_wr_data[SIZE_WIDTH-1:0];
          end
          if (w_srst || w_launch || w_zero_job) begin
            r_cycles <= '0;
          end else if (w_count && (r_cycles != 32'hFFFF_FFFF)) begin
            r_cycles <= r_cycles + 32'd1;
          end
          // Hardware set takes priority over a software W1C in the same cycle.
          if (w_zero_job || w_finish) begin
            r_done_sticky <= 1'b1;
          end else if (w_launch) begin
            r_done_sticky <= 1'b0;
          end else if (w_wr_status && mmio_wr_data[1]) begin
            r_done_sticky <= 1'b0;
          end
          if (w_busy_go) begin
            r_err_sticky <= 1'b1;
          end else if (w_wr_status && mmio_wr_data[2]) begin
            r_err_sticky <= 1'b0;
          end
        end
      end

      always_comb begin
        w_rd_val = '0;
        if (w_rd_even) begin
          if (mmio_rd_addr == c_CH_BASE) begin
            w_rd_val[2:1] = {r_unhalt, r_soft_reset};
          end else if (mmio_rd_addr == c_CH_BASE + 16'd2) begin
            w_rd_val[ADDR_WIDTH-1:0] = r_start;
          end else if (mmio_rd_addr == c_CH_BASE + 16'd4) begin
            w_rd_val[SIZE_WIDTH-1:0] = r_size;
          end else if (mmio_rd_addr == c_CH_BASE + 16'd6) begin
            w_rd_val[2:0] = {r_err_sticky, r_done_sticky, w_busy};
          end else if (mmio_rd_addr == c_CH_BASE + 16'd8) begin
            w_rd_val[31:0] = r_cycles;
          end
        end
      end

      assign w_rd_ch[c]                                = w_rd_val;
      assign start_addr[c*ADDR_WIDTH +: ADDR_WIDTH]    = r_start;
      assign size[c*SIZE_WIDTH +: SIZE_WIDTH]          = r_size;
      assign go[c]                                     = r_go;
      assign soft_reset[c]                             = r_soft_reset;
      assign unhalt[c]                                 = r_unhalt;
    end
  endgenerate

  // Each channel returns zero unless addressed, so the channel values can be OR-merged.
  always_comb begin
    w_rd_mux = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_rd_mux = w_rd_mux | w_rd_ch[c];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (mmio_rd_en) begin
      r_rd_data <= w_rd_mux;
    end
  end

  assign mmio_rd_data     = r_rd_data;
  assign w_unused_wr_data = ^mmio_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_mmio_ctrl_regs.sv
`default_nettype none
// Testbench for mmio_ctrl_regs: directed scenarios followed by random traffic
// checked against a behavioural register/job model.
module tb_mmio_ctrl_regs;

  localparam int NUM_CH = 2;
  localparam int AW     = 64;
  localparam int SW     = 32;
  localparam int BASE   = 'h50;
  localparam int STRIDE = 'h10;
  localparam int M_IDLE = 0, M_BUSY = 1, M_DONE = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  mmio_wr_en;
  logic [15:0]           mmio_wr_addr;
  logic [63:0]           mmio_wr_data;
  logic                  mmio_rd_en;
  logic [15:0]           mmio_rd_addr;
  logic [63:0]           mmio_rd_data;
  logic [NUM_CH*AW-1:0]  start_addr;
  logic [NUM_CH*SW-1:0]  size;
  logic [NUM_CH-1:0]     go;
  logic [NUM_CH-1:0]     soft_reset;
  logic [NUM_CH-1:0]     unhalt;
  logic [NUM_CH-1:0]     done;

  mmio_ctrl_regs #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                   .BASE_ADDR(16'h0050), .CH_STRIDE(16'h0010)) dut (
    .clk(clk), .rst(rst),
    .mmio_wr_en(mmio_wr_en), .mmio_wr_addr(mmio_wr_addr), .mmio_wr_data(mmio_wr_data),
    .mmio_rd_en(mmio_rd_en), .mmio_rd_addr(mmio_rd_addr), .mmio_rd_data(mmio_rd_data),
    .start_addr(start_addr), .size(size), .go(go),
    .soft_reset(soft_reset), .unhalt(unhalt), .done(done)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int          m_st     [NUM_CH];
  logic [63:0] m_start  [NUM_CH];
  logic [31:0] m_size   [NUM_CH];
  logic [31:0] m_cyc    [NUM_CH];
  bit          m_dst    [NUM_CH];
  bit          m_est    [NUM_CH];
  bit          m_srst   [NUM_CH];
  bit          m_unhalt [NUM_CH];
  logic [NUM_CH-1:0] exp_go;
  logic [63:0]       exp_rd;

  int n_asserts = 0;
  int n_fail    = 0;

  function automatic int ch_base(input int c);
    return BASE + c * STRIDE;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_st[c] = M_IDLE; m_start[c] = '0; m_size[c] = '0; m_cyc[c] = '0;
      m_dst[c] = 0; m_est[c] = 0; m_srst[c] = 0; m_unhalt[c] = 0;
    end
    exp_go = '0;
    exp_rd = '0;
  endtask

  function automatic logic [63:0] m_read(input logic [15:0] addr);
    if (addr[0]) return 64'h0;
    for (int c = 0; c < NUM_CH; c++) begin
      int off;
      off = int'(addr) - ch_base(c);
      case (off)
        0: return {61'h0, m_unhalt[c], m_srst[c], 1'b0};
        2: return m_start[c];
        4: return {32'h0, m_size[c]};
        6: return {61'h0, m_est[c], m_dst[c], (m_st[c] == M_BUSY)};
        8: return {32'h0, m_cyc[c]};
        default: ;
      endcase
    end
    return 64'h0;
  endfunction

  // One rising edge of the register bank, computed from the job rules.
  task automatic model_edge();
    logic [63:0] rd_next;
    rd_next = mmio_rd_en ? m_read(mmio_rd_addr) : exp_rd;
    for (int c = 0; c < NUM_CH; c++) begin
      int off;
      bit was_busy, go_req;
      off = (mmio_wr_en && !mmio_wr_addr[0]) ? (int'(mmio_wr_addr) - ch_base(c)) : -1;
      was_busy  = (m_st[c] == M_BUSY);
      go_req    = (off == 0) && mmio_wr_data[0];
      exp_go[c] = 1'b0;
      if (off == 0) begin
        m_srst[c]   = mmio_wr_data[1];
        m_unhalt[c] = mmio_wr_data[2];
      end
      if (off == 2 && !was_busy) m_start[c] = mmio_wr_data;
      if (off == 4 && !was_busy) m_size[c] = mmio_wr_data[31:0];
      if (off == 6 && mmio_wr_data[1]) m_dst[c] = 0;
      if (off == 6 && mmio_wr_data[2]) m_est[c] = 0;
      if (m_srst[c]) begin
        m_st[c]  = M_IDLE;
        m_cyc[c] = 0;
      end else if (was_busy) begin
        if (m_cyc[c] != 32'hFFFF_FFFF) m_cyc[c] = m_cyc[c] + 1;
        if (go_req) m_est[c] = 1;
        if (done[c]) begin
          m_dst[c] = 1;
          m_st[c]  = M_DONE;
        end
      end else if (go_req) begin
        m_cyc[c] = 0;
        if (m_size[c] == 0) begin
          m_st[c]  = M_DONE;
          m_dst[c] = 1;
        end else begin
          m_st[c]   = M_BUSY;
          m_dst[c]  = 0;
          exp_go[c] = 1'b1;
        end
      end
    end
    exp_rd = rd_next;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic compare_all();
    logic [NUM_CH-1:0] e_srst, e_unh;
    for (int c = 0; c < NUM_CH; c++) begin
      e_srst[c] = m_srst[c];
      e_unh[c]  = m_unhalt[c];
      check("start_addr", start_addr[c*AW +: AW], m_start[c]);
      check("size", 64'(size[c*SW +: SW]), 64'(m_size[c]));
    end
    check("go", 64'(go), 64'(exp_go));
    check("soft_reset", 64'(soft_reset), 64'(e_srst));
    check("unhalt", 64'(unhalt), 64'(e_unh));
    check("rd_data", mmio_rd_data, exp_rd);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) m_reset();
    else model_edge();
    #1;
    compare_all();
    mmio_wr_en = 1'b0;
    mmio_rd_en = 1'b0;
    done       = '0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d);
    mmio_wr_en = 1'b1; mmio_wr_addr = a; mmio_wr_data = d;
    tick();
  endtask

  task automatic rd(input logic [15:0] a, output logic [63:0] d);
    mmio_rd_en = 1'b1; mmio_rd_addr = a;
    tick();
    d = mmio_rd_data;
  endtask

  initial begin
    #2_000_000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rv, d;
    logic [15:0] a;
    int ch, off;

    rst = 1'b1; mmio_wr_en = 0; mmio_wr_addr = 0; mmio_wr_data = 0;
    mmio_rd_en = 0; mmio_rd_addr = 0; done = '0;
    m_reset();
    repeat (2) tick();
    check("reset_go", 64'(go), 64'h0);
    check("reset_rd", mmio_rd_data, 64'h0);
    rst = 1'b0;
    tick();

    // Channel 1 job launch
    wr(16'h0062, 64'h1000);
    wr(16'h0064, 64'd4);
    wr(16'h0060, 64'h1);
    check("ch1_go_pulse", 64'(go), 64'h2);
    tick();
    check("ch1_go_single", 64'(go), 64'h0);
    rd(16'h0066, rv); check("ch1_status_busy", rv, 64'h1);
    repeat (7) tick();
    done = 2'b10;
    tick();
    rd(16'h0066, rv); check("ch1_status_done", rv, 64'h2);
    rd(16'h0068, rv); check("ch1_cycles", rv, 64'd10);
    wr(16'h0066, 64'h2);
    rd(16'h0066, rv); check("ch1_status_w1c", rv, 64'h0);

    // Zero-size job on channel 0
    wr(16'h0054, 64'h0);
    wr(16'h0050, 64'h1);
    check("ch0_zero_nogo", 64'(go), 64'h0);
    rd(16'h0056, rv); check("ch0_zero_status", rv, 64'h2);
    rd(16'h0058, rv); check("ch0_zero_cycles", rv, 64'h0);

    // Go and SIZE while busy; done vs W1C in the same cycle
    wr(16'h0054, 64'd5);
    wr(16'h0050, 64'h1);
    check("ch0_go_pulse", 64'(go), 64'h1);
    wr(16'h0050, 64'h1);
    check("ch0_busy_nogo", 64'(go), 64'h0);
    wr(16'h0054, 64'd9);
    rd(16'h0054, rv); check("ch0_size_kept", rv, 64'd5);
    rd(16'h0056, rv); check("ch0_status_err", rv, 64'h5);
    done = 2'b01;
    wr(16'h0056, 64'h2);
    rd(16'h0056, rv); check("ch0_set_wins", rv, 64'h6);

    // Odd / unmapped addresses, control levels, reset mid-job
    rd(16'h0051, rv); check("rd_odd", rv, 64'h0);
    rd(16'h00F0, rv); check("rd_unmapped", rv, 64'h0);
    wr(16'h0053, 64'hFFFF);
    wr(16'h0050, 64'h2);
    check("ch0_soft_reset", 64'(soft_reset), 64'h1);
    wr(16'h0060, 64'h4);
    check("ch1_unhalt", 64'(unhalt), 64'h2);
    wr(16'h0060, 64'h5);
    check("ch1_go_again", 64'(go), 64'h2);
    rst = 1'b1;
    #1;
    m_reset();
    check("rst_go", 64'(go), 64'h0);
    check("rst_srst", 64'(soft_reset), 64'h0);
    check("rst_unhalt", 64'(unhalt), 64'h0);
    check("rst_rd", mmio_rd_data, 64'h0);
    tick();
    rst = 1'b0;
    rd(16'h0062, rv); check("rst_start", rv, 64'h0);
    rd(16'h0066, rv); check("rst_status", rv, 64'h0);
    rd(16'h0068, rv); check("rst_cycles", rv, 64'h0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        ch  = $urandom_range(0, NUM_CH - 1);
        off = 2 * $urandom_range(0, 4);
        case (off)
          0: d = {61'h0, 1'($urandom), ($urandom_range(0, 7) == 0), 1'($urandom)};
          2: d = {$urandom, $urandom};
          4: d = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
          6: d = 64'($urandom_range(0, 7));
          default: d = {$urandom, $urandom};
        endcase
        a = 16'(ch_base(ch) + off);
        case ($urandom_range(0, 9))
          0: a = a | 16'h1;
          1: a = 16'h00F0;
          default: ;
        endcase
        mmio_wr_en = 1'b1; mmio_wr_addr = a; mmio_wr_data = d;
      end
      if ($urandom_range(0, 1) == 0) begin
        mmio_rd_en   = 1'b1;
        mmio_rd_addr = 16'(ch_base($urandom_range(0, NUM_CH - 1)) + $urandom_range(0, 9));
      end
      for (int c = 0; c < NUM_CH; c++) done[c] = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
